// File: rtl/imem_loader_pkg.sv
// Shared MIPS32 instruction-memory definitions: halt encoding and loader FSM states.
// The optional checksum stage (IMEM_LOADER_CHECKSUM_EN) reuses the CKSUM encoding here.
package imem_loader_pkg;

  localparam logic [5:0]  HALT_FUNCT = 6'd13;
  localparam logic [31:0] HALT_WORD  = {26'd0, HALT_FUNCT};

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    LOAD  = 3'd1,
    CKSUM = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction loader.
// A byte transfers on a rising clock edge where in_valid and in_ready are both high.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8-to-32 assembler: three bytes wait in staging, the fourth completes
// the word combinationally so the caller can write it on the same edge.
module imem_loader_byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] staging;

  always_ff @(posedge clock) begin
    if (reset) begin
      idx     <= 2'd0;
      staging <= 24'd0;
    end else if (byte_valid) begin
      idx     <= idx + 2'd1;
      // Newest byte enters at the top so the first byte ends up in bits [7:0].
      staging <= {byte_data, staging[23:8]};
    end
  end

  assign word_valid = byte_valid && (idx == 2'd3);
  assign word       = {byte_data, staging};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: header N, 4N little-endian payload bytes, then serves instr.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte before RUN.
module imem_loader #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] HALT_WORD  = imem_loader_pkg::HALT_WORD
) (
  input  logic                    clock,
  input  logic                    reset,
  imem_loader_if.slave            stream,
  input  logic [31:0]             raddr,
  output logic [31:0]             instr,
  output logic                    run,
  output logic                    error,
  output logic [ADDR_WIDTH:0]     words_loaded,
  output imem_loader_pkg::state_t dbg_state
);
  import imem_loader_pkg::*;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  state_t          state, state_next;
  logic [CW-1:0]   n_words;
  logic [CW-1:0]   wl;
  logic [31:0]     mem [DEPTH];
  logic            accept, load_byte, hdr_ok, last_word;
  logic            word_valid;
  logic [31:0]     word;

  assign accept    = stream.in_valid && stream.in_ready;
  assign load_byte = accept && (state == LOAD);
  assign hdr_ok    = (stream.in_data != 8'd0) && (32'(stream.in_data) <= 32'(DEPTH));
  assign last_word = word_valid && ((wl + CW'(1)) == n_words);

  imem_loader_byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .byte_valid (load_byte),
    .byte_data  (stream.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum <= 8'd0;
    end else if (accept && (state == HDR)) begin
      sum <= stream.in_data;
    end else if (load_byte) begin
      sum <= sum + stream.in_data;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HDR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (accept) state_next = hdr_ok ? LOAD : ERR;
      end
      LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (last_word) state_next = CKSUM;
`else
        if (last_word) state_next = RUN;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CKSUM: begin
        if (accept) state_next = (stream.in_data == sum) ? RUN : ERR;
      end
`endif
      RUN:     state_next = RUN;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n_words <= '0;
      wl      <= '0;
    end else begin
      if (accept && (state == HDR) && hdr_ok) n_words <= CW'(stream.in_data);
      if (word_valid) wl <= wl + CW'(1);
    end
  end

  // Store has no reset; stale words stay hidden behind the n_words bound.
  always_ff @(posedge clock) begin
    if (word_valid) mem[wl[ADDR_WIDTH-1:0]] <= word;
  end

  always_comb begin
    instr = 32'h0;
    if (state == RUN) begin
      instr = (raddr < 32'(n_words)) ? mem[raddr[ADDR_WIDTH-1:0]] : HALT_WORD;
    end
  end

  assign stream.in_ready = (state != RUN);
  assign run             = (state == RUN);
  assign error           = (state == ERR);
  assign words_loaded    = wl;
  assign dbg_state       = state;

endmodule
